// File: rtl/mdu_divider.sv
// mdu_divider
// Iterative restoring divider for the M-extension execute stage. Handles
// DIV, DIVU, REM and REMU on WIDTH-bit operands, producing one quotient
// bit per cycle. Divide-by-zero and signed overflow bypass the iteration
// and complete on the cycle after accept.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_valid     request present (accepted when req_ready and no flush)
//   req_ready     high while idle
//   op            00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend      rs1, sampled at accept
//   divisor       rs2, sampled at accept
//   flush         abort the current operation, no response
//   busy          high while calculating or presenting the response
//   resp_valid    one-cycle response pulse
//   result        quotient (op[1]=0) or remainder (op[1]=1), held until
//                 the next response
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       op_q;
    logic             q_neg;
    logic             r_neg;
    // Holds the dividend magnitude at accept; dividend bits shift out of
    // the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;

    logic             is_signed;
    logic             div_zero;
    logic             sgn_ovf;
    logic             accept;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? WIDTH'(-v) : v;
    endfunction

    assign is_signed = ~op[0];
    assign div_zero  = (divisor == '0);
    assign sgn_ovf   = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (divisor == '1);
    assign accept    = req_valid && (state == S_IDLE) && !flush;

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state == S_CALC) || (state == S_DONE);
    assign resp_valid = (state == S_DONE);

    // Restoring step: bring down the next dividend bit, keep the difference
    // only when it does not go negative.
    always_comb begin
        rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
        q_bit  = (rem_sh >= {1'b0, dvs_q});
        diff   = rem_sh - {1'b0, dvs_q};
        rem_nx = q_bit ? diff : rem_sh;
        quo_nx = {quo_q[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt_q  <= CNT_W'(WIDTH - 1);
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt_q <= CNT_W'(WIDTH - 1);
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cnt_q <= CNT_W'(WIDTH - 1);
                        if (div_zero) begin
                            state  <= S_DONE;
                            result <= op[1] ? dividend : '1;
                        end else if (sgn_ovf) begin
                            state  <= S_DONE;
                            result <= op[1] ? '0 : dividend;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q == '0) begin
                        state  <= S_DONE;
                        result <= op_q[1] ? cond_neg(rem_nx[WIDTH-1:0], r_neg)
                                          : cond_neg(quo_nx, q_neg);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op;
            q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed && dividend[WIDTH-1];
            quo_q <= magnitude(dividend, is_signed);
            dvs_q <= magnitude(divisor, is_signed);
            rem_q <= '0;
        end else if (state == S_CALC) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
module tb_mdu_divider;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv   [2];
    logic        fl   [2];
    logic [1:0]  opv  [2];
    logic [31:0] a_in [2];
    logic [31:0] b_in [2];
    logic        rdy  [2];
    logic        bsy  [2];
    logic        rsp  [2];
    logic [31:0] res32;
    logic [7:0]  res8;

    // Literal expectations attached to the next accepted request.
    bit          lit_arm [2];
    logic [31:0] lit_val [2];
    int          lit_lat [2];

    int n_chk  = 0;
    int n_fail = 0;
    int wd [2] = '{32, 8};

    always #5 clk = ~clk;

    mdu_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .op(opv[0]),
        .dividend(a_in[0]), .divisor(b_in[0]), .flush(fl[0]), .busy(bsy[0]),
        .resp_valid(rsp[0]), .result(res32)
    );

    mdu_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .op(opv[1]),
        .dividend(a_in[1][7:0]), .divisor(b_in[1][7:0]), .flush(fl[1]), .busy(bsy[1]),
        .resp_valid(rsp[1]), .result(res8)
    );

    // Reference: plain integer arithmetic with the RISC-V special cases.
    function automatic logic [31:0] ref_div(input int w, input logic [1:0] o,
                                            input logic [31:0] a, input logic [31:0] b,
                                            output bit fast);
        longint one = 1;
        longint mask, ua, ub, sa, sb, q, r;
        mask = (one << w) - one;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        fast = 1'b0;
        if (ub == 0) begin
            q = mask; r = ua; fast = 1'b1;
        end else if (!o[0] && sa == -(one << (w - 1)) && sb == -one) begin
            q = ua; r = 0; fast = 1'b1;
        end else if (!o[0]) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = ua / ub; r = ua % ub;
        end
        return 32'(o[1] ? (r & mask) : (q & mask));
    endfunction

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return m;
            2: return 32'd1 << (w - 1);
            3: return 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (w%0d) at %0t: actual=%h required=%h", name, wd[i], $time, act, exp);
        end
    endtask

    // Compare process: checks both instances every cycle against the model,
    // then advances the model for the coming edge.
    bit          m_init = 1'b0;
    int          m_left [2] = '{0, 0};
    logic [31:0] m_res  [2];
    logic [31:0] m_pend [2];
    bit          l_on   [2] = '{1'b0, 1'b0};
    logic [31:0] l_val  [2];
    int          l_lat  [2];
    int          l_cnt  [2];

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [31:0] ro;
                bit fast;
                ro = (i == 0) ? res32 : {24'h0, res8};
                if (m_init) begin
                    chk("req_ready", i, 32'(rdy[i]), 32'(m_left[i] == 0));
                    chk("busy", i, 32'(bsy[i]), 32'(m_left[i] != 0));
                    chk("resp_valid", i, 32'(rsp[i]), 32'(m_left[i] == 1));
                    chk("result", i, ro, m_res[i]);
                    if (l_on[i]) begin
                        l_cnt[i]++;
                        if (rsp[i] === 1'b1) begin
                            chk("lit_result", i, ro, l_val[i]);
                            chk("lit_latency", i, 32'(l_cnt[i]), 32'(l_lat[i]));
                            l_on[i] = 1'b0;
                        end else if (l_cnt[i] > 40) begin
                            chk("lit_timeout", i, 32'(l_cnt[i]), 32'(l_lat[i]));
                            l_on[i] = 1'b0;
                        end
                    end
                end
                if (rst) begin
                    m_init    = 1'b1;
                    m_left[i] = 0;
                    m_res[i]  = 32'd0;
                    l_on[i]   = 1'b0;
                end else if (m_left[i] == 0) begin
                    if (rv[i] && !fl[i]) begin
                        m_pend[i] = ref_div(wd[i], opv[i], a_in[i], b_in[i], fast);
                        m_left[i] = fast ? 1 : wd[i] + 1;
                        if (fast) m_res[i] = m_pend[i];
                        l_on[i]  = lit_arm[i];
                        l_val[i] = lit_val[i];
                        l_lat[i] = lit_lat[i];
                        l_cnt[i] = 0;
                    end
                end else if (fl[i]) begin
                    m_left[i] = 0;
                    l_on[i]   = 1'b0;
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 1) m_res[i] = m_pend[i];
                end
            end
        end
    end

    // Present one request for one cycle; afterwards scramble the operand
    // inputs, then wait gap cycles. Returns one step after the accept edge.
    task automatic issue(input int i, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit arm, input logic [31:0] val,
                         input int lat, input int gap);
        @(posedge clk); #1;
        rv[i] = 1'b1; opv[i] = o; a_in[i] = a; b_in[i] = b;
        lit_arm[i] = arm; lit_val[i] = val; lit_lat[i] = lat;
        @(posedge clk); #1;
        rv[i] = 1'b0; lit_arm[i] = 1'b0;
        a_in[i] = $urandom; b_in[i] = $urandom; opv[i] = 2'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; fl[i] = 1'b0; opv[i] = 2'd0; a_in[i] = 32'd0; b_in[i] = 32'd0;
            lit_arm[i] = 1'b0; lit_val[i] = 32'd0; lit_lat[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed WIDTH=32 cases (back-to-back spacing)
        issue(0, OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 33, 32);
        issue(0, OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, 33, 32);
        issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 33, 32);
        issue(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 33, 32);
        issue(0, OP_REM, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 33, 32);
        issue(0, OP_DIV, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1, 2);
        issue(0, OP_REMU, 32'd5, 32'd0, 1'b1, 32'd5, 1, 2);
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1, 2);
        issue(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, 2);
        issue(0, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 33, 32);

        // Flush in cycle 10, new request in cycle 11
        issue(0, OP_DIVU, 32'd12345, 32'd17, 1'b0, 32'd0, 0, 0);
        repeat (9) @(posedge clk);
        #1 fl[0] = 1'b1;
        @(posedge clk); #1;
        fl[0] = 1'b0;
        rv[0] = 1'b1; opv[0] = OP_DIVU; a_in[0] = 32'd1000; b_in[0] = 32'd3;
        lit_arm[0] = 1'b1; lit_val[0] = 32'd333; lit_lat[0] = 33;
        @(posedge clk); #1;
        rv[0] = 1'b0; lit_arm[0] = 1'b0;
        repeat (33) @(posedge clk);
        // Flush together with a request while idle: not accepted
        #1 fl[0] = 1'b1; rv[0] = 1'b1; opv[0] = OP_DIVU; a_in[0] = 32'd9; b_in[0] = 32'd2;
        @(posedge clk); #1;
        fl[0] = 1'b0; rv[0] = 1'b0;
        repeat (3) @(posedge clk);
        // Flush during the response cycle
        issue(0, OP_DIVU, 32'd77, 32'd0, 1'b1, 32'hFFFF_FFFF, 1, 0);
        fl[0] = 1'b1;
        @(posedge clk); #1 fl[0] = 1'b0;
        repeat (2) @(posedge clk);
        // Reset in the middle of an operation
        issue(0, OP_DIV, 32'd999, 32'd4, 1'b0, 32'd0, 0, 5);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Directed WIDTH=8 cases
        issue(1, OP_DIV, 32'h81, 32'h03, 1'b1, 32'hD6, 9, 8);
        issue(1, OP_REM, 32'h81, 32'h03, 1'b1, 32'hFF, 9, 8);

        // Random operands against the model
        for (int n = 0; n < 40; n++)
            issue(0, 2'($urandom), rnd_opnd(32), rnd_opnd(32), 1'b0, 32'd0, 0,
                  32 + $urandom_range(0, 2));
        for (int n = 0; n < 120; n++)
            issue(1, 2'($urandom), rnd_opnd(8), rnd_opnd(8), 1'b0, 32'd0, 0,
                  8 + $urandom_range(0, 2));

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
